// File: rtl/multi_cycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// opcodes, state encoding and datapath select encodings.
package multi_cycle_ctrl_fsm_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcEcall  = 7'b1110011;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5
    } state_e;

    localparam logic [1:0] WbAluOut  = 2'b00;
    localparam logic [1:0] WbMdr     = 2'b01;
    localparam logic [1:0] WbPc      = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluFunct  = 2'b01;
    localparam logic [1:0] AluBranch = 2'b10;

    localparam logic PcSrcAlu    = 1'b0;
    localparam logic PcSrcAluOut = 1'b1;

    localparam logic IordPc     = 1'b0;
    localparam logic IordAluOut = 1'b1;

    function automatic logic is_known_opc(logic [6:0] opc);
        return opc inside {OpcR, OpcI, OpcLoad, OpcStore, OpcBranch, OpcJal, OpcJalr, OpcEcall};
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_fsm_ctrl_next_state.sv
// Combinational next-state logic for the multi-cycle control sequencer.
module multi_cycle_ctrl_fsm_ctrl_next_state
    import multi_cycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OPC_W = 7
) (
    input  logic [2:0]       state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic [2:0]       next_state
);

    state_e ns;

    always_comb begin
        ns = state_e'(state);
        unique case (state_e'(state))
            StIf: begin
                if (mem_ready) ns = StId;
            end
            StId: begin
                if (opcode == OpcEcall) begin
                    ns = halt_req ? StHalt : StIf;
                end else if (is_known_opc(opcode)) begin
                    ns = StEx;
                end else begin
                    ns = StIf;
                end
            end
            StEx: begin
                case (opcode)
                    OpcR, OpcI:         ns = StWb;
                    OpcLoad, OpcStore:  ns = StMem;
                    default:            ns = StIf;
                endcase
            end
            StMem: begin
                if (mem_ready) ns = (opcode == OpcLoad) ? StWb : StIf;
            end
            StWb:    ns = StIf;
            StHalt:  ns = StHalt;
            default: ns = StIf;
        endcase
    end

    assign next_state = ns;

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: state register, output decode and, with
// MULTI_CYCLE_PERF_CNT_EN defined, cycle and retired-instruction counters.
module multi_cycle_ctrl_fsm
    import multi_cycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OPC_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic             pc_source,
    output logic             is_halted
`ifdef MULTI_CYCLE_PERF_CNT_EN
    ,
    output logic [31:0]      cycle_count,
    output logic [31:0]      instr_count
`endif
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] next_state;

    multi_cycle_ctrl_fsm_ctrl_next_state #(
        .OPC_W (OPC_W)
    ) u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .next_state (next_state)
    );

    assign state_d = state_e'(next_state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    // Gated by reset so a pending request drops the instant reset asserts.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = IordPc;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = WbAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op_sel = AluAdd;
        pc_source  = PcSrcAlu;
        is_halted  = 1'b0;
        if (reset) begin
            unique case (state_q)
                StIf: begin
                    mem_read = 1'b1;
                    iord     = IordPc;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_a  = SrcAPc;
                        alu_src_b  = SrcBFour;
                        alu_op_sel = AluAdd;
                        pc_source  = PcSrcAlu;
                    end
                end
                StId: begin
                    alu_src_a  = SrcAOldPc;
                    alu_src_b  = SrcBImm;
                    alu_op_sel = AluAdd;
                end
                StEx: begin
                    case (opcode)
                        OpcR: begin
                            alu_src_a  = SrcARs1;
                            alu_src_b  = SrcBRs2;
                            alu_op_sel = AluFunct;
                        end
                        OpcI: begin
                            alu_src_a  = SrcARs1;
                            alu_src_b  = SrcBImm;
                            alu_op_sel = AluFunct;
                        end
                        OpcLoad, OpcStore: begin
                            alu_src_a  = SrcARs1;
                            alu_src_b  = SrcBImm;
                            alu_op_sel = AluAdd;
                        end
                        OpcBranch: begin
                            alu_src_a  = SrcARs1;
                            alu_src_b  = SrcBRs2;
                            alu_op_sel = AluBranch;
                            if (bcond) begin
                                pc_write  = 1'b1;
                                pc_source = PcSrcAluOut;
                            end
                        end
                        OpcJal: begin
                            pc_write  = 1'b1;
                            pc_source = PcSrcAluOut;
                            reg_write = 1'b1;
                            wb_sel    = WbPc;
                        end
                        OpcJalr: begin
                            alu_src_a  = SrcARs1;
                            alu_src_b  = SrcBImm;
                            alu_op_sel = AluAdd;
                            pc_write   = 1'b1;
                            pc_source  = PcSrcAlu;
                            reg_write  = 1'b1;
                            wb_sel     = WbPc;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    iord      = IordAluOut;
                    mem_read  = (opcode == OpcLoad);
                    mem_write = (opcode == OpcStore);
                end
                StWb: begin
                    reg_write = 1'b1;
                    wb_sel    = (opcode == OpcLoad) ? WbMdr : WbAluOut;
                end
                StHalt: begin
                    is_halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTI_CYCLE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state_q != StHalt) cycle_count <= cycle_count + 32'd1;
            if ((state_q inside {StId, StEx, StMem, StWb}) && (state_d == StIf)) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Self-checking bench for multi_cycle_ctrl_fsm: per-instruction phase model with
// randomized memory waits and don't-care inputs.
module tb_multi_cycle_ctrl_fsm;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] JR = 7'b1100111;
    localparam logic [6:0] EC = 7'b1110011;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op_sel;
        logic       pc_source;
        logic       is_halted;
    } outs_t;

    typedef struct {
        logic [6:0] opc;
        logic       bc;
        logic       hr;
        logic       mr;
        outs_t      exp;
        string      ph;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       bcond, halt_req, mem_ready;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op_sel;
    logic       pc_source, is_halted;
`ifdef MULTI_CYCLE_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int    checks;
    int    errors;
    ent_t  sq[$];
    outs_t act;

    multi_cycle_ctrl_fsm #(
        .OPC_W (7)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .opcode     (opcode),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op_sel (alu_op_sel),
        .pc_source  (pc_source),
        .is_halted  (is_halted)
`ifdef MULTI_CYCLE_PERF_CNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample_outs();
        return {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op_sel, pc_source, is_halted};
    endfunction

    // Called at a falling edge; drives, samples, and returns at the next falling edge.
    task automatic cyc(input logic [6:0] opc, input logic bc, input logic hr, input logic mr);
        opcode    = opc;
        bcond     = bc;
        halt_req  = hr;
        mem_ready = mr;
        #1;
        act = sample_outs();
        @(negedge clk);
    endtask

    function automatic logic known(logic [6:0] o);
        return o inside {R, I, LD, ST, BR, JL, JR, EC};
    endfunction

    function automatic void push(logic [6:0] opc, logic bc, logic hr, logic mr, outs_t o,
                                 string ph);
        ent_t e;
        e.opc = opc;
        e.bc  = bc;
        e.hr  = hr;
        e.mr  = mr;
        e.exp = o;
        e.ph  = ph;
        sq.push_back(e);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, phase by phase.
    function automatic void model_instr(logic [6:0] opc, int if_wait, int mem_wait,
                                        logic bc, logic hr);
        outs_t o;
        for (int i = 0; i <= if_wait; i++) begin
            o = '0;
            o.mem_read = 1'b1;
            if (i == if_wait) begin
                o.ir_write  = 1'b1;
                o.pc_write  = 1'b1;
                o.alu_src_b = 2'b01;
            end
            push(7'($urandom), 1'($urandom), 1'($urandom), (i == if_wait), o, "IF");
        end
        o = '0;
        o.alu_src_a = 2'b01;
        o.alu_src_b = 2'b10;
        push(opc, 1'($urandom), (opc == EC) ? hr : 1'($urandom), 1'($urandom), o, "ID");
        if (!known(opc) || opc == EC) return;
        o = '0;
        case (opc)
            R:  begin o.alu_src_a = 2'b10; o.alu_op_sel = 2'b01; end
            I:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; o.alu_op_sel = 2'b01; end
            LD, ST: begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; end
            BR: begin
                o.alu_src_a  = 2'b10;
                o.alu_op_sel = 2'b10;
                o.pc_write   = bc;
                o.pc_source  = bc;
            end
            JL: begin o.pc_write = 1'b1; o.pc_source = 1'b1; o.reg_write = 1'b1; o.wb_sel = 2'b10; end
            default: begin
                o.alu_src_a = 2'b10;
                o.alu_src_b = 2'b10;
                o.pc_write  = 1'b1;
                o.reg_write = 1'b1;
                o.wb_sel    = 2'b10;
            end
        endcase
        push(opc, (opc == BR) ? bc : 1'($urandom), 1'($urandom), 1'($urandom), o, "EX");
        if (opc == LD || opc == ST) begin
            for (int i = 0; i <= mem_wait; i++) begin
                o = '0;
                o.iord      = 1'b1;
                o.mem_read  = (opc == LD);
                o.mem_write = (opc == ST);
                push(opc, 1'($urandom), 1'($urandom), (i == mem_wait), o, "MEM");
            end
        end
        if (opc == R || opc == I || opc == LD) begin
            o = '0;
            o.reg_write = 1'b1;
            o.wb_sel    = (opc == LD) ? 2'b01 : 2'b00;
            push(opc, 1'($urandom), 1'($urandom), 1'($urandom), o, "WB");
        end
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want %h", act, 16'h0);
            end
        end
        rst_n = 1'b1;
        model_instr(I, 0, 0, 1'b0, 1'b0);
        while (sq.size() != 0) begin
            ent_t e;
            e = sq.pop_front();
            cyc(e.opc, e.bc, e.hr, e.mr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL reset_release %s: got %h want %h", e.ph, act, e.exp);
            end
        end
    endtask

    task automatic test_rtype();
        int irw = 0;
        model_instr(R, 0, 0, 1'b0, 1'b0);
        while (sq.size() != 0) begin
            ent_t e;
            e = sq.pop_front();
            cyc(e.opc, e.bc, e.hr, e.mr);
            irw += int'(act.ir_write);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL rtype %s: got %h want %h", e.ph, act, e.exp);
            end
        end
        checks++;
        if (irw != 1) begin
            errors++;
            $display("FAIL rtype_ir_write_count: got %0d want 1", irw);
        end
    endtask

    task automatic test_load_wait();
        int held = 0;
        model_instr(LD, 0, 3, 1'b0, 1'b0);
        while (sq.size() != 0) begin
            ent_t e;
            e = sq.pop_front();
            cyc(e.opc, e.bc, e.hr, e.mr);
            if (act.mem_read && act.iord) held++;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL load_wait %s: got %h want %h", e.ph, act, e.exp);
            end
        end
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL load_wait_hold: got %0d want 4", held);
        end
    endtask

    task automatic test_branch_jump();
        model_instr(BR, 0, 0, 1'b0, 1'b0);
        model_instr(BR, 1, 0, 1'b1, 1'b0);
        model_instr(JR, 0, 0, 1'b0, 1'b0);
        model_instr(JL, 2, 0, 1'b0, 1'b0);
        while (sq.size() != 0) begin
            ent_t e;
            e = sq.pop_front();
            cyc(e.opc, e.bc, e.hr, e.mr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL branch_jump %s op=%b: got %h want %h", e.ph, e.opc, act, e.exp);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[9];
        logic [6:0] unk[4];
        ops = '{R, I, LD, ST, BR, JL, JR, EC, 7'b0};
        unk = '{7'b0110111, 7'b0010111, 7'b0001111, 7'b0000000};
        for (int n = 0; n < 150; n++) begin
            logic [6:0] opc;
            int k;
            k = int'($urandom_range(0, 8));
            opc = (k == 8) ? unk[$urandom_range(0, 3)] : ops[k];
            model_instr(opc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'($urandom), 1'b0);
            while (sq.size() != 0) begin
                ent_t e;
                e = sq.pop_front();
                cyc(e.opc, e.bc, e.hr, e.mr);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL random #%0d %s op=%b: got %h want %h", n, e.ph, e.opc, act,
                             e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int mem_seen = 0;
        model_instr(ST, 0, 5, 1'b0, 1'b0);
        while (mem_seen < 2 && sq.size() != 0) begin
            ent_t e;
            e = sq.pop_front();
            cyc(e.opc, e.bc, e.hr, e.mr);
            if (e.ph == "MEM") mem_seen++;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL mid_wait %s: got %h want %h", e.ph, act, e.exp);
            end
        end
        sq.delete();
        #2;
        rst_n = 1'b0;
        #1;
        act = sample_outs();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL mid_wait_async_drop: got %h want %h", act, 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        checks++;
        if (act !== 16'h1000) begin
            errors++;
            $display("FAIL mid_wait_restart_if: got %h want %h", act, 16'h1000);
        end
    endtask

    task automatic test_halt();
        outs_t h;
        h = '0;
        h.is_halted = 1'b1;
        model_instr(EC, 1, 0, 1'b0, 1'b0);
        model_instr(EC, 0, 0, 1'b0, 1'b1);
        while (sq.size() != 0) begin
            ent_t e;
            e = sq.pop_front();
            cyc(e.opc, e.bc, e.hr, e.mr);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL halt_entry %s: got %h want %h", e.ph, act, e.exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (act !== h) begin
                errors++;
                $display("FAIL halt_hold cycle %0d: got %h want %h", i, act, h);
            end
        end
        rst_n = 1'b0;
        cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL halt_reset: got %h want %h", act, 16'h0);
        end
        rst_n = 1'b1;
        cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        checks++;
        if (act !== 16'h1000) begin
            errors++;
            $display("FAIL halt_exit_if: got %h want %h", act, 16'h1000);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        opcode    = '0;
        bcond     = 1'b0;
        halt_req  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch_jump();
        test_random();
        test_reset_mid_wait();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
